// File: rtl/ysyx_23060184_axi_sram.sv
// ysyx_23060184_axi_sram
// AXI4-lite SRAM responder serving one transaction at a time from a
// 2**DEPTH_LOG2 x 32-bit word array mapped at BASE_ADDR.
//
// Ports:
//   clk, rstn                        clock, asynchronous active-low reset
//   araddr/arvalid/arready           read address channel
//   rdata/rresp/rvalid/rready        read data channel
//   awaddr/awvalid/awready           write address channel
//   wdata/wstrb/wvalid/wready        write data channel (byte strobes)
//   bresp/bvalid/bready/bid          write response channel (bid tied to 0)
//
// Optional feature macro: YSYX_23060184_SRAM_RAND_DELAY_EN
//   When defined, each response delay is LATENCY plus lfsr[2:0] taken from an
//   8-bit Fibonacci LFSR sampled at the request handshake.
//   When undefined, the delay is the fixed LATENCY and no LFSR exists.
module ysyx_23060184_axi_sram #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic [3:0]  bid
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    R_WAIT = 3'd1,
    R_RESP = 3'd2,
    W_DATA = 3'd3,
    W_WAIT = 3'd4,
    W_RESP = 3'd5
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [4:0]         cnt_r, cnt_nxt_s;
  logic [31:0]        addr_r, addr_nxt_s;
  logic [31:0]        rdata_r, rdata_nxt_s;
  logic [1:0]         rresp_r, rresp_nxt_s;
  logic [1:0]         bresp_r, bresp_nxt_s;
  logic               arready_r, awready_r, wready_r, rvalid_r, bvalid_r;
  logic [31:0]        mem_r [WORDS];

  logic [4:0]         delay_s;
  logic [31:0]        look_addr_s;
  logic [31:0]        offset_s;
  logic [DEPTH_LOG2-1:0] idx_s;
  logic               err_s;
  logic               unused_s;

`ifdef YSYX_23060184_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_r;
  logic       lfsr_fb_s;

  assign lfsr_fb_s = lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3];

  // Free-running LFSR (taps 8,6,5,4) providing the random delay component
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr_r <= 8'hA5;
    end else begin
      lfsr_r <= {lfsr_r[6:0], lfsr_fb_s};
    end
  end

  assign delay_s = 5'(LATENCY) + {2'b00, lfsr_r[2:0]};
`else
  assign delay_s = 5'(LATENCY);
`endif

  // In IDLE the incoming read address is decoded directly so a zero-delay
  // read can fetch its data in the handshake cycle; elsewhere the latched one.
  assign look_addr_s = (state_r == IDLE) ? araddr : addr_r;
  assign offset_s    = look_addr_s - BASE_ADDR;
  assign idx_s       = offset_s[DEPTH_LOG2+1:2];
  assign err_s       = |offset_s[31:DEPTH_LOG2+2];
  assign unused_s    = ^offset_s[1:0];

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; reads take priority over writes in IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (arvalid) begin
          state_nxt_s = (delay_s == 5'd0) ? R_RESP : R_WAIT;
        end else if (awvalid) begin
          state_nxt_s = W_DATA;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      R_WAIT: begin
        if (cnt_r <= 5'd1) state_nxt_s = R_RESP;
        else               state_nxt_s = R_WAIT;
      end
      R_RESP: begin
        if (rready) state_nxt_s = IDLE;
        else        state_nxt_s = R_RESP;
      end
      W_DATA: begin
        if (wvalid) state_nxt_s = (delay_s == 5'd0) ? W_RESP : W_WAIT;
        else        state_nxt_s = W_DATA;
      end
      W_WAIT: begin
        if (cnt_r <= 5'd1) state_nxt_s = W_RESP;
        else               state_nxt_s = W_WAIT;
      end
      W_RESP: begin
        if (bready) state_nxt_s = IDLE;
        else        state_nxt_s = W_RESP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath next values: address latch, delay counter, response payloads
  always_comb begin
    addr_nxt_s  = addr_r;
    cnt_nxt_s   = cnt_r;
    rdata_nxt_s = rdata_r;
    rresp_nxt_s = rresp_r;
    bresp_nxt_s = bresp_r;
    case (state_r)
      IDLE: begin
        if (arvalid)      addr_nxt_s = araddr;
        else if (awvalid) addr_nxt_s = awaddr;
        else              addr_nxt_s = addr_r;
        cnt_nxt_s = delay_s;
      end
      W_DATA: cnt_nxt_s = delay_s;
      R_WAIT, W_WAIT: cnt_nxt_s = cnt_r - 5'd1;
      default: cnt_nxt_s = cnt_r;
    endcase
    // Response payload is captured once, on entry to the response state
    if ((state_nxt_s == R_RESP) && (state_r != R_RESP)) begin
      rdata_nxt_s = err_s ? 32'h0 : mem_r[idx_s];
      rresp_nxt_s = err_s ? 2'b11 : 2'b00;
    end else begin
      rdata_nxt_s = rdata_r;
      rresp_nxt_s = rresp_r;
    end
    if ((state_nxt_s == W_RESP) && (state_r != W_RESP)) begin
      bresp_nxt_s = err_s ? 2'b11 : 2'b00;
    end else begin
      bresp_nxt_s = bresp_r;
    end
  end

  // Registered datapath and handshake outputs, derived from the next state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_r    <= 32'h0;
      cnt_r     <= 5'd0;
      rdata_r   <= 32'h0;
      rresp_r   <= 2'b00;
      bresp_r   <= 2'b00;
      arready_r <= 1'b0;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      rvalid_r  <= 1'b0;
      bvalid_r  <= 1'b0;
    end else begin
      addr_r    <= addr_nxt_s;
      cnt_r     <= cnt_nxt_s;
      rdata_r   <= rdata_nxt_s;
      rresp_r   <= rresp_nxt_s;
      bresp_r   <= bresp_nxt_s;
      arready_r <= (state_nxt_s == IDLE);
      awready_r <= (state_nxt_s == IDLE);
      wready_r  <= (state_nxt_s == W_DATA);
      rvalid_r  <= (state_nxt_s == R_RESP);
      bvalid_r  <= (state_nxt_s == W_RESP);
    end
  end

  // Byte-lane array write on the W handshake; contents survive reset
  always_ff @(posedge clk) begin
    if (rstn && (state_r == W_DATA) && wvalid && !err_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem_r[idx_s][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign arready = arready_r;
  assign awready = awready_r;
  assign wready  = wready_r;
  assign rvalid  = rvalid_r;
  assign rdata   = rdata_r;
  assign rresp   = rresp_r;
  assign bvalid  = bvalid_r;
  assign bresp   = bresp_r;
  assign bid     = 4'd0;

endmodule

// File: tb/tb_ysyx_23060184_axi_sram.sv
// Self-checking bench for ysyx_23060184_axi_sram (default parameters).
// Expected responses are pushed to a scoreboard queue when a request is
// driven and popped when the DUT presents the response.
module tb_ysyx_23060184_axi_sram;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] araddr = 32'h0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] awaddr = 32'h0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  wstrb = 4'h0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  bid;

  always #5 clk = ~clk;

  ysyx_23060184_axi_sram #(
    .BASE_ADDR (32'h8000_0000),
    .DEPTH_LOG2(10),
    .LATENCY   (LAT)
  ) dut (
    .clk(clk), .rstn(rstn),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .bid(bid)
  );

  int          checks = 0;
  int          failures = 0;
  logic [1:0]  exp_resp_q [$];
  logic [31:0] exp_data_q [$];
  logic [31:0] model_mem [int];
  logic [31:0] wr_addr = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] resp_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'h8000_0000;
    return (off < 32'h0000_1000) ? 2'b00 : 2'b11;
  endfunction

  function automatic int key_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'h8000_0000;
    return int'(off >> 2);
  endfunction

  task automatic ar_phase(input logic [31:0] a, input logic [1:0] er, input logic [31:0] ed);
    int n;
    n = 0;
    araddr = a;
    arvalid = 1'b1;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    chk("arready_wait", 32'(arready), 32'd1);
    exp_resp_q.push_back(er);
    exp_data_q.push_back(ed);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic r_phase(input int hold);
    int n;
    logic [31:0] d0;
    n = 1;
    while (!rvalid && n < 64) begin @(negedge clk); n++; end
    chk("rvalid_seen", 32'(rvalid), 32'd1);
`ifdef YSYX_23060184_SRAM_RAND_DELAY_EN
    chk("r_latency_range", 32'((n >= LAT + 1) && (n <= LAT + 8)), 32'd1);
`else
    chk("r_latency", 32'(n), 32'(LAT + 1));
`endif
    d0 = rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("r_hold_valid", 32'(rvalid), 32'd1);
      chk("r_hold_data", rdata, d0);
    end
    if (exp_resp_q.size() == 0) begin
      chk("r_scoreboard_empty", 32'd0, 32'd1);
    end else begin
      chk("rresp", 32'(rresp), 32'(exp_resp_q.pop_front()));
      chk("rdata", rdata, exp_data_q.pop_front());
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("r_done_rvalid", 32'(rvalid), 32'd0);
    chk("r_done_arready", 32'(arready), 32'd1);
  endtask

  task automatic read_exp(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er, input int hold);
    ar_phase(a, er, ed);
    r_phase(hold);
  endtask

  task automatic read_word(input logic [31:0] a, input int hold);
    logic [1:0]  r;
    logic [31:0] d;
    int k;
    r = resp_of(a);
    k = key_of(a);
    d = (r == 2'b00 && model_mem.exists(k)) ? model_mem[k] : 32'h0;
    read_exp(a, d, r, hold);
  endtask

  task automatic aw_phase(input logic [31:0] a);
    int n;
    n = 0;
    awaddr = a;
    awvalid = 1'b1;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    chk("awready_wait", 32'(awready), 32'd1);
    wr_addr = a;
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic w_phase(input logic [31:0] d, input logic [3:0] s);
    int n;
    int k;
    logic [31:0] m;
    n = 0;
    wdata = d;
    wstrb = s;
    wvalid = 1'b1;
    while (!wready && n < 50) begin @(negedge clk); n++; end
    chk("wready_wait", 32'(wready), 32'd1);
    if (resp_of(wr_addr) == 2'b00) begin
      k = key_of(wr_addr);
      m = model_mem.exists(k) ? model_mem[k] : 32'h0;
      for (int i = 0; i < 4; i++) begin
        if (s[i]) m[8*i +: 8] = d[8*i +: 8];
      end
      model_mem[k] = m;
    end
    exp_resp_q.push_back(resp_of(wr_addr));
    exp_data_q.push_back(32'h0);
    @(negedge clk);
    wvalid = 1'b0;
  endtask

  task automatic b_phase();
    int n;
    logic [31:0] unused_d;
    n = 1;
    while (!bvalid && n < 64) begin @(negedge clk); n++; end
    chk("bvalid_seen", 32'(bvalid), 32'd1);
`ifdef YSYX_23060184_SRAM_RAND_DELAY_EN
    chk("b_latency_range", 32'((n >= LAT + 1) && (n <= LAT + 8)), 32'd1);
`else
    chk("b_latency", 32'(n), 32'(LAT + 1));
`endif
    chk("bid", 32'(bid), 32'd0);
    if (exp_resp_q.size() == 0) begin
      chk("b_scoreboard_empty", 32'd0, 32'd1);
    end else begin
      chk("bresp", 32'(bresp), 32'(exp_resp_q.pop_front()));
      unused_d = exp_data_q.pop_front();
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("b_done_bvalid", 32'(bvalid), 32'd0);
    chk("b_done_awready", 32'(awready), 32'd1);
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    aw_phase(a);
    w_phase(d, s);
    b_phase();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rel_arready", 32'(arready), 32'd1);
    chk("rel_awready", 32'(awready), 32'd1);

    // Write then read, low address bits ignored
    write_word(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    read_exp(32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 0);
    read_exp(32'h8000_0013, 32'hDEAD_BEEF, 2'b00, 0);

    // Partial strobe
    write_word(32'h8000_0020, 32'h1122_3344, 4'hF);
    write_word(32'h8000_0020, 32'hAABB_CCDD, 4'b0101);
    read_exp(32'h8000_0020, 32'h11BB_33DD, 2'b00, 0);

    // Backpressure: rready held low for 5 cycles
    read_word(32'h8000_0010, 5);

    // Last word and first word
    write_word(32'h8000_0FFC, 32'hCAFE_F00D, 4'hF);
    write_word(32'h8000_0000, 32'h0BAD_F00D, 4'hF);
    read_exp(32'h8000_0FFC, 32'hCAFE_F00D, 2'b00, 0);

    // Decode errors
    read_exp(32'h7FFF_FFFC, 32'h0, 2'b11, 0);
    read_exp(32'h8000_1000, 32'h0, 2'b11, 0);
    write_word(32'h8000_1000, 32'hFFFF_FFFF, 4'hF);
    read_exp(32'h8000_0000, 32'h0BAD_F00D, 2'b00, 0);
    read_exp(32'h8000_0FFC, 32'hCAFE_F00D, 2'b00, 0);

    // Priority: AR and AW raised together, read served first
    araddr = 32'h8000_0020;
    awaddr = 32'h8000_0030;
    arvalid = 1'b1;
    awvalid = 1'b1;
    chk("prio_arready", 32'(arready), 32'd1);
    exp_resp_q.push_back(2'b00);
    exp_data_q.push_back(32'h11BB_33DD);
    @(negedge clk);
    arvalid = 1'b0;
    chk("prio_awready_blocked", 32'(awready), 32'd0);
    r_phase(0);
    chk("prio_aw_pending", 32'(awready), 32'd1);
    wr_addr = awaddr;
    @(negedge clk);
    awvalid = 1'b0;
    w_phase(32'h5A5A_A5A5, 4'hF);
    b_phase();
    read_exp(32'h8000_0030, 32'h5A5A_A5A5, 2'b00, 0);

    // Assorted data patterns with full then partial strobes
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      a = 32'h8000_0100 + 32'(i * 4 * 37);
      write_word(a, $urandom, 4'hF);
      write_word(a, $urandom, 4'($urandom_range(0, 15)));
      read_word(a, i % 3);
    end

    // Reset in the middle of R_WAIT
    araddr = 32'h8000_0010;
    arvalid = 1'b1;
    chk("rstmid_arready", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("rstmid_arready0", 32'(arready), 32'd0);
    chk("rstmid_awready0", 32'(awready), 32'd0);
    chk("rstmid_wready0", 32'(wready), 32'd0);
    chk("rstmid_rvalid0", 32'(rvalid), 32'd0);
    chk("rstmid_bvalid0", 32'(bvalid), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rstrel_arready", 32'(arready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("rstrel_rvalid", 32'(rvalid), 32'd0);
      @(negedge clk);
    end

    // Reset during W_DATA with wvalid high: array must be untouched
    aw_phase(32'h8000_0010);
    wdata = 32'h0000_0000;
    wstrb = 4'hF;
    wvalid = 1'b1;
    chk("rstw_wready", 32'(wready), 32'd1);
    #1;
    rstn = 1'b0;
    @(negedge clk);
    wvalid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    read_exp(32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 0);

`ifdef YSYX_23060184_SRAM_RAND_DELAY_EN
    for (int i = 0; i < 100; i++) begin
      case (i % 4)
        0:       read_exp(32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 0);
        1:       read_exp(32'h8000_0020, 32'h11BB_33DD, 2'b00, 0);
        2:       read_exp(32'h8000_0FFC, 32'hCAFE_F00D, 2'b00, 0);
        default: read_exp(32'h8000_0000, 32'h0BAD_F00D, 2'b00, 0);
      endcase
    end
`endif

    chk("scoreboard_drained", 32'(exp_resp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_23060184_axi_sram.md
YSYX_23060184_AXI_SRAM -- requirements
Module: ysyx_23060184_axi_sram

Interface
REQ-001 SHALL have parameter BASE_ADDR, 32'h8000_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH_LOG2, 10, log2 of the number of 32-bit words stored.
REQ-003 SHALL have parameter LATENCY, 1, extra cycles between an accepted request and its response (0..15).
REQ-004 SHALL have clk  in  1  single clock; all state updates on posedge.
REQ-005 SHALL have rstn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have araddr  in  32  read address; arvalid  in  1; arready  out  1.
REQ-007 SHALL have rdata  out  32; rresp  out  2; rvalid  out  1; rready  in  1.
REQ-008 SHALL have awaddr  in  32; awvalid  in  1; awready  out  1.
REQ-009 SHALL have wdata  in  32; wstrb  in  4  byte enables; wvalid  in  1; wready  out  1.
REQ-010 SHALL have bresp  out  2; bvalid  out  1; bready  in  1; bid  out  4  (ID_WIDTH), constant 0.

Function
REQ-011 SHALL be an AXI4-lite responder for one outstanding transaction at a time; FSM states IDLE, R_WAIT, R_RESP, W_DATA, W_WAIT, W_RESP.
REQ-012 SHALL drive arready=1 and awready=1 only in IDLE; all other states drive both 0.
REQ-013 SHALL, in IDLE with arvalid=1, accept the read (latch araddr) and go to R_WAIT; reads win when arvalid and awvalid are both 1 in the same cycle.
REQ-014 SHALL, in IDLE with awvalid=1 and arvalid=0, latch awaddr and go to W_DATA.
REQ-015 SHALL drive wready=1 only in W_DATA; on wvalid&wready, write each byte lane i of wdata with wstrb[i]=1, then go to W_WAIT.
REQ-016 SHALL count the delay in R_WAIT/W_WAIT; after the handshake at cycle T, rvalid/bvalid rises at cycle T+1+delay (delay=LATENCY; LATENCY=0 skips the wait state).
REQ-017 SHALL hold rvalid, rdata and rresp stable in R_RESP until rready=1, then return to IDLE in the next cycle.
REQ-018 SHALL hold bvalid and bresp stable in W_RESP until bready=1, then return to IDLE.
REQ-019 SHALL compute the offset as address minus BASE_ADDR (32-bit wrap); the word index is offset[DEPTH_LOG2+1:2]; offset[1:0] is ignored.
REQ-020 SHALL respond DECERR (2'b11) when offset >= 4<<DEPTH_LOG2, with rdata=0 and no array write; in-range responses are OKAY (2'b00).
REQ-021 SHALL return the data as it stood after any write completed before the read handshake; there is no read-during-write hazard, because transactions are serialized.
REQ-022 SHALL ignore wvalid outside W_DATA and rready/bready outside the response states.

Reset
REQ-023 SHALL, while rstn=0, force state IDLE, delay counter 0, and arready, awready, wready, rvalid, bvalid=0; rdata=0, rresp=0, bresp=0.
REQ-024 SHALL assert arready/awready in the first posedge after rstn deasserts.
REQ-025 SHALL abandon any in-flight transaction on reset without writing the array; array contents are not reset.

Configuration
REQ-026 SHALL, with YSYX_23060184_SRAM_RAND_DELAY_EN defined, use delay = LATENCY + lfsr[2:0].
REQ-027 SHALL, under that macro, use an 8-bit Fibonacci LFSR (taps 8,6,5,4) that resets to 8'hA5 and advances every cycle; the value is sampled at the request handshake.
REQ-028 SHALL, without the macro, omit the LFSR entirely and use the fixed delay = LATENCY.

Verification
REQ-029 SHALL check reset: rstn=0 mid-R_WAIT -> all valids/readies 0 immediately; after release, arready=1 on the next cycle and rvalid stays 0.
REQ-030 SHALL check write then read: write 0x80000010 <- 32'hDEADBEEF (wstrb 4'hF), LATENCY=1 -> bvalid 2 cycles after the w handshake with bresp 0; read 0x80000010 -> rdata 32'hDEADBEEF, rresp 0.
REQ-031 SHALL check partial strobe: preload 32'h11223344, write 32'hAABBCCDD with wstrb 4'b0101 -> readback 32'h11BB33DD.
REQ-032 SHALL check backpressure and priority: rready held 0 for 5 cycles -> rvalid/rdata stable throughout; arvalid and awvalid raised in the same cycle -> read served first, write accepted afterwards.
REQ-033 SHALL check decode error: read 0x7FFFFFFC and 0x80001000 (DEPTH_LOG2=10) -> rresp 2'b11, rdata 0; write to 0x80001000 -> bresp 2'b11, array unchanged.
REQ-034 SHALL check random delay (macro on): 100 reads -> every response latency lies in LATENCY+1..LATENCY+8 and the data is correct.
